// File: rtl/rv_int_pkg.sv
// Shared definitions for the RV integer register-immediate execute path:
// funct3 encodings, execute-unit state encoding and default datapath width.
package rv_int_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } exec_state_e;

  function automatic logic is_shift_op(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
  endfunction

endpackage

// File: rtl/shift_stepper.sv
// Iterative shifter: moves the operand by up to SHIFT_STEP bits per cycle
// until the latched shift amount is used up.
module shift_stepper #(
  parameter  int XLEN       = 32,
  parameter  int SHIFT_STEP = 1,
  localparam int SW         = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            dir,
  input  logic            arith,
  input  logic [XLEN-1:0] operand,
  input  logic [SW-1:0]   shamt,
  output logic [XLEN-1:0] result,
  output logic            done
);

  // A step wider than the largest possible shamt is clipped so it fits SW bits.
  localparam logic [SW-1:0] STEP_C = (SHIFT_STEP >= XLEN) ? SW'(XLEN - 1) : SW'(SHIFT_STEP);

  logic [XLEN-1:0] val_q, val_d;
  logic [SW-1:0]   rem_q, rem_d;
  logic            dir_q, dir_d;
  logic            arith_q, arith_d;
  logic [SW-1:0]   step_s;
  logic [SW-1:0]   rem_next_s;
  logic [XLEN-1:0] val_shift_s;

  // One shift step plus the next-state selection for load / advance / hold.
  always_comb begin
    if (32'(rem_q) < 32'(SHIFT_STEP)) begin
      step_s = rem_q;
    end else begin
      step_s = STEP_C;
    end

    if (!dir_q) begin
      val_shift_s = val_q << step_s;
    end else if (arith_q) begin
      val_shift_s = XLEN'($signed(val_q) >>> step_s);
    end else begin
      val_shift_s = val_q >> step_s;
    end

    rem_next_s = rem_q - step_s;
    result     = val_shift_s;
    done       = (rem_q != {SW{1'b0}}) && (rem_next_s == {SW{1'b0}});

    val_d   = val_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    if (load) begin
      val_d   = operand;
      rem_d   = shamt;
      dir_d   = dir;
      arith_d = arith;
    end else if (rem_q != {SW{1'b0}}) begin
      val_d = val_shift_s;
      rem_d = rem_next_s;
    end else begin
      val_d = val_q;
      rem_d = rem_q;
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q   <= {XLEN{1'b0}};
      rem_q   <= {SW{1'b0}};
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

endmodule

// File: rtl/int_imm_exec_unit.sv
// Multi-cycle execute unit for RV register-immediate integer ops with
// valid/ready handshakes on both sides and an iterative shifter.
module int_imm_exec_unit
  import rv_int_pkg::*;
#(
  parameter  int XLEN       = XLEN_DEFAULT,
  parameter  int IMM_W      = 12,
  parameter  int SHIFT_STEP = 1,
  localparam int SW         = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [IMM_W-1:0] imm,
  input  logic [XLEN-1:0]  rs1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  rd_data,
  output logic             busy
);

  exec_state_e     state_q, state_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [XLEN-1:0] simm_s;
  logic [SW-1:0]   shamt_s;
  logic [XLEN-1:0] alu_res_s;
  logic            accept_s;
  logic            load_s;
  logic            shift_dir_s;
  logic [XLEN-1:0] shift_res_s;
  logic            shift_done_s;

  assign simm_s      = {{(XLEN - IMM_W){imm[IMM_W-1]}}, imm};
  assign shamt_s     = imm[SW-1:0];
  assign shift_dir_s = (funct3 == F3_SRL_SRA);
  assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s    = in_valid && in_ready;
  assign out_valid   = out_valid_q;
  assign rd_data     = rd_data_q;
  assign busy        = busy_q;

  // Single-cycle results; a zero-distance shift simply passes rs1 through.
  always_comb begin
    alu_res_s = rs1;
    case (funct3)
      F3_ADD:     alu_res_s = rs1 + simm_s;
      F3_SLT:     alu_res_s = {{(XLEN - 1){1'b0}}, ($signed(rs1) < $signed(simm_s))};
      F3_SLTU:    alu_res_s = {{(XLEN - 1){1'b0}}, (rs1 < simm_s)};
      F3_XOR:     alu_res_s = rs1 ^ simm_s;
      F3_OR:      alu_res_s = rs1 | simm_s;
      F3_AND:     alu_res_s = rs1 & simm_s;
      F3_SLL:     alu_res_s = rs1;
      F3_SRL_SRA: alu_res_s = rs1;
      default:    alu_res_s = rs1;
    endcase
  end

  shift_stepper #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift_stepper (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .dir     (shift_dir_s),
    .arith   (imm[10]),
    .operand (rs1),
    .shamt   (shamt_s),
    .result  (shift_res_s),
    .done    (shift_done_s)
  );

  // Next-state logic; retiring in DONE and accepting a new op can share a cycle.
  always_comb begin
    state_d     = state_q;
    rd_data_d   = rd_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    load_s      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d     = state_q;
        end
        if (accept_s) begin
          if (is_shift_op(funct3) && (shamt_s != {SW{1'b0}})) begin
            load_s      = 1'b1;
            state_d     = ST_SHIFT;
            busy_d      = 1'b1;
            out_valid_d = 1'b0;
          end else begin
            rd_data_d   = alu_res_s;
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (shift_done_s) begin
          rd_data_d   = shift_res_s;
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d     = ST_SHIFT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_data_q   <= {XLEN{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_data_q   <= rd_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule
